// File: rtl/spi_cfg_regs.sv
// spi_cfg_regs: SPI mode-0 write-only configuration target.
// Receives 16-bit frames {rw, addr[6:0], data[7:0]} MSB first and commits
// writes into five 8-bit control registers used by the PWM/output stage.
// SCLK/COPI/nCS are asynchronous to clk and are synchronised here.
module spi_cfg_regs #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCLK,
  input  logic       COPI,
  input  logic       nCS,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  // Pin bit order inside the synchroniser: {nCS, COPI, SCLK}.
  // Idle bus reset value: SCLK low, COPI low, nCS high.
  localparam logic [2:0] PIN_RST  = 3'b100;
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic                        sclk_h;
  logic                        cs_h;
  logic                        sclk_s;
  logic                        copi_s;
  logic                        cs_s;
  logic                        sclk_rise;
  logic                        cs_fall;
  logic                        cs_rise;

  state_t                      state;
  state_t                      state_nxt;
  logic                        fall_pend;
  logic                        start;
  logic                        shift_en;
  logic                        commit;

  logic [15:0]                 shreg;
  logic [4:0]                  cnt;
  logic [6:0]                  addr;
  logic                        len_ok;
  logic                        addr_ok;
  logic [4:0][7:0]             cfg;

  // Synchroniser chain: stage 0 samples the pins, each stage shifts one deeper.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{PIN_RST}};
    end else begin
      sync_q[0] <= {nCS, COPI, SCLK};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sclk_s = sync_q[SYNC_STAGES-1][0];
  assign copi_s = sync_q[SYNC_STAGES-1][1];
  assign cs_s   = sync_q[SYNC_STAGES-1][2];

  // History flops for edge detection. nCS history resets high so a pin held
  // low through reset produces a fresh cs_fall once reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_h <= 1'b0;
      cs_h   <= 1'b1;
    end else begin
      sclk_h <= sclk_s;
      cs_h   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_h;
  assign cs_fall   = ~cs_s & cs_h;
  assign cs_rise   = cs_s & ~cs_h;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A cs_fall arriving during COMMIT is remembered and consumed in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          fall_pend <= 1'b0;
    else if (state == COMMIT && cs_fall) fall_pend <= 1'b1;
    else if (state == IDLE)              fall_pend <= 1'b0;
  end

  // Frame decode, evaluated while the frame sits in COMMIT.
  assign addr    = shreg[14:8];
  assign len_ok  = (cnt == CNT_FULL);
  assign addr_ok = (addr <= MAX_ADDR);

  // Next-state logic and the commit pulses. cs_rise takes priority over a
  // coincident sclk_rise, so that last bit is dropped.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    wr_strobe = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall || fall_pend) begin
          state_nxt = SHIFT;
          start     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise)        state_nxt = COMMIT;
        else if (sclk_rise) shift_en  = 1'b1;
      end
      COMMIT: begin
        state_nxt = IDLE;
        commit    = 1'b1;
        wr_strobe = len_ok & shreg[15] & addr_ok;
        frame_err = ~len_ok | ~addr_ok;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter; the counter parks at 17 to flag an
  // overlength frame without wrapping back to a legal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= 16'h0000;
      cnt   <= 5'd0;
    end else if (start) begin
      shreg <= 16'h0000;
      cnt   <= 5'd0;
    end else if (shift_en) begin
      shreg <= {shreg[14:0], copi_s};
      cnt   <= (cnt == CNT_SAT) ? CNT_SAT : cnt + 5'd1;
    end
  end

  // Register file: exactly one entry written per valid write frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (wr_strobe && addr < 7'd5) begin
      cfg[addr[2:0]] <= shreg[7:0];
    end
  end

  assign en_reg_out_7_0  = cfg[0];
  assign en_reg_out_15_8 = cfg[1];
  assign en_reg_pwm_7_0  = cfg[2];
  assign en_reg_pwm_15_8 = cfg[3];
  assign pwm_duty_cycle  = cfg[4];

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Directed bench for spi_cfg_regs with an event scoreboard: expected
// strobe/error events are queued as frames are driven and popped as the
// DUT pulses wr_strobe / frame_err.
module tb_spi_cfg_regs;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SCLK = 1'b0;
  logic       COPI = 1'b0;
  logic       nCS = 1'b1;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_strobe, frame_err;

  spi_cfg_regs #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [5];
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_reg(input int a);
    case (a)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      default: return r4;
    endcase
  endfunction

  // Queue the expected outcome of an n-bit frame (bits[n-1] sent first).
  // Returns 1 for a write, 2 for an error, 0 for a silently ignored frame.
  function automatic int expect_frame(input logic [16:0] bits, input int n);
    exp_t       e;
    logic [6:0] a;
    a = bits[14:8];
    if (n != 16 || a > 7'h04) begin
      e.err = 1'b1; e.addr = 3'd0; e.data = 8'h00;
      sb.push_back(e);
      return 2;
    end
    if (bits[15]) begin
      e.err = 1'b0; e.addr = a[2:0]; e.data = bits[7:0];
      sb.push_back(e);
      mdl[a] = bits[7:0];
      return 1;
    end
    return 0;
  endfunction

  // Scoreboard monitor; register contents are checked one clk after the strobe.
  logic       pend_v = 1'b0;
  logic [2:0] pend_a;
  logic [7:0] pend_d;
  always @(negedge clk) begin
    exp_t e;
    if (pend_v) begin
      chk("reg_after_strobe", {24'h0, get_reg(int'(pend_a))}, {24'h0, pend_d});
      pend_v = 1'b0;
    end
    if (rst_n && (wr_strobe || frame_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'h0, wr_strobe, frame_err}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("event_kind", {30'h0, wr_strobe, frame_err}, e.err ? 32'h1 : 32'h2);
        if (!e.err) begin
          pend_v = 1'b1; pend_a = e.addr; pend_d = e.data;
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk); nCS = 1'b0;
    wait_clk(6);
  endtask

  task automatic shift_bits(input logic [16:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); COPI = bits[i];
      wait_clk(4); SCLK = 1'b1;
      wait_clk(4); SCLK = 1'b0;
    end
    wait_clk(4);
  endtask

  // Raise nCS; for a write the strobe must appear SYNC+1 clk later.
  task automatic cs_high(input int kind);
    @(negedge clk); nCS = 1'b1;
    if (kind == 1) begin
      repeat (SYNC + 1) @(posedge clk);
      @(negedge clk);
      chk("strobe_latency", {31'h0, wr_strobe}, 32'h1);
    end
    wait_clk(10);
  endtask

  task automatic send(input logic [16:0] bits, input int n);
    int k;
    k = expect_frame(bits, n);
    cs_low();
    shift_bits(bits, n);
    cs_high(k);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++) chk(tag, {24'h0, get_reg(i)}, {24'h0, mdl[i]});
    chk("sb_drained", sb.size(), 32'h0);
  endtask

  task automatic do_reset(input logic cs_val);
    @(negedge clk); rst_n = 1'b0; nCS = cs_val; SCLK = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    check_regs("reset_regs");
    chk("reset_strobe", {30'h0, wr_strobe, frame_err}, 32'h0);

    // 1: basic write to address 0
    send(17'h080F0, 16);
    check_regs("t1_regs");

    // 2: two writes to different registers
    send(17'h08480, 16);
    send(17'h083A5, 16);
    check_regs("t2_regs");

    // 3: read frame is ignored
    send(17'h004FF, 16);
    check_regs("t3_regs");

    // 4: 15-bit and 17-bit frames carrying 0x8155 are errors
    send(17'h08155 >> 1, 15);
    send({16'h8155, 1'b0}, 17);
    check_regs("t4_regs");

    // 5: out-of-range address, then a valid frame
    send(17'h08555, 16);
    send(17'h08233, 16);
    check_regs("t5_regs");

    // SCLK activity with nCS high must not disturb anything
    shift_bits(17'h1FFFF, 6);
    send(17'h0817E, 16);
    check_regs("idle_sclk_regs");

    // cs_fall landing in COMMIT: back-to-back frames, nCS high for one clk
    k = expect_frame(17'h08401, 16);
    k = expect_frame(17'h08302, 16);
    cs_low();
    shift_bits(17'h08401, 16);
    @(negedge clk); nCS = 1'b1;
    @(negedge clk); nCS = 1'b0;
    wait_clk(6);
    shift_bits(17'h08302, 16);
    cs_high(1);
    check_regs("b2b_regs");

    // 6: reset mid-frame, then a fresh frame
    cs_low();
    shift_bits(17'h00080, 8);
    do_reset(1'b1);
    wait_clk(4);
    check_regs("t6_reset_regs");
    send(17'h08011, 16);
    check_regs("t6_regs");

    // nCS held low through reset starts a frame after release
    do_reset(1'b0);
    k = expect_frame(17'h08122, 16);
    wait_clk(6);
    shift_bits(17'h08122, 16);
    cs_high(k);
    check_regs("cs_low_reset_regs");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
